// File: rtl/rtype_instr_encoder.sv
// rtype_instr_encoder: ALU control code + register indices -> R-type instruction word, FIFO-buffered
module rtype_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_illegal,
  output logic [7:0]       illegal_count,
  output logic [CNT_W-1:0] instr_count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic full, empty, accept, legal, push, pop;
  always_comb begin
    funct3 = 3'd0;
    case (in_alu_op[2:0])
      3'b000: funct3 = 3'd7;
      3'b001: funct3 = 3'd6;
      3'b011: funct3 = 3'd1;
      3'b101: funct3 = 3'd5;
      3'b110: funct3 = 3'd2;
      3'b111: funct3 = 3'd4;
      default: funct3 = 3'd0;
    endcase
  end
  assign funct7 = in_alu_op == 4'b0100 ? 7'h20 : 7'h00;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign out_valid = !empty;
  assign out_instr = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign legal = !in_alu_op[3];
  assign accept = in_valid && in_ready;
  assign push = accept && legal;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_illegal <= 1'b0;
      illegal_count <= 8'd0;
      instr_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      err_illegal <= accept && !legal;
      illegal_count <= (accept && !legal && illegal_count != 8'hFF) ? illegal_count + 8'd1 : illegal_count;
      instr_count <= instr_count + CNT_W'(push);
    end
endmodule

// File: doc/rtype_instr_encoder.md
Name: rtype_instr_encoder

Overview:
- Inverse of the R-type control decoder: takes an ALU control code plus register indices and emits the 32-bit R-type instruction word that the decoder maps back to the same alu_control.
- Requests enter over a valid/ready handshake and are buffered in a small FIFO; instruction words leave over a second valid/ready handshake.
- Used by self-test sequencers and instruction-stream generators that drive the decode path.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the encoded-instruction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_alu_op  input  4  ALU control code.
- in_rd  input  5  destination register index.
- in_rs1  input  5  source register 1 index.
- in_rs2  input  5  source register 2 index.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- out_instr  output  32  encoded instruction at the FIFO head; 0 when empty.
- err_illegal  output  1  one-cycle pulse for an accepted request with an unsupported op.
- illegal_count  output  8  count of illegal requests, saturating.
- instr_count  output  CNT_W  count of instructions pushed into the FIFO, wrapping.

Behaviour:
- Reset (async assert, sync deassert) clears the FIFO and pointers. Reset values: out_valid=0, out_instr=0, err_illegal=0, illegal_count=0, instr_count=0, in_ready=1.
- Encoding: instr = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- Op map (alu_op -> funct3/funct7):
  - 0010 ADD -> 0/0
  - 0100 SUB -> 0/0x20
  - 0001 OR -> 6/0
  - 0000 AND -> 7/0
  - 0011 SLL -> 1/0
  - 0101 SRL -> 5/0
  - 0110 MUL -> 2/0
  - 0111 XOR -> 4/0
- Codes 1000-1111 are illegal.
- in_ready = FIFO not full. in_ready is independent of in_alu_op and in_valid, with no combinational path from out_ready. A full FIFO does not accept a push even when a pop occurs in the same cycle.
- Legal accepted request: the word is written at wr_ptr at the clock edge and visible on out_valid/out_instr the next cycle (latency 1, no fall-through). instr_count increments by 1 and wraps at 2^CNT_W.
- Illegal accepted request: nothing is written to the FIFO. err_illegal is high for exactly the following cycle. illegal_count increments and holds at 255. The request is consumed (handshake completes).
- Pop: on out_valid && out_ready the read pointer advances, and the next entry (or 0 if now empty) is presented the next cycle.
- out_instr is stable while out_valid && !out_ready.
- Simultaneous legal push and pop on a non-full, non-empty FIFO: occupancy unchanged.
- Simultaneous push and pop on an empty FIFO: the pop is ignored (out_valid was 0) and the push lands.
- Pointers are log2(DEPTH)+1 bits with natural wrap; full/empty are derived from the MSB-differs / equal comparison.
- rd/rs1/rs2 are encoded verbatim, including x0.
- Reset asserted mid-stream discards all buffered words immediately (async). No partial word is emitted after reset.

Test Plan:
- Reset, then push ADD (0010) rd=1 rs1=2 rs2=3 with out_ready=1 -> out_valid high next cycle, out_instr=0x003100B3, instr_count=1.
- Push SUB (0100) rd=5 rs1=6 rs2=7, then XOR (0111) rd=10 rs1=11 rs2=12, then MUL (0110) rd=1 rs1=1 rs2=1 -> words 0x407302B3, 0x00C5C533, 0x0010A0B3 emerge in order.
- Hold out_ready=0 and push 5 legal requests -> in_ready drops after the 4th accept and the 5th is held. Pulse out_ready for one cycle -> 5th accepted the cycle after the FIFO becomes non-full; FIFO order is preserved and out_instr is stable while stalled.
- Push alu_op=1010 -> no FIFO write, err_illegal is a single-cycle pulse, illegal_count=1. Issue 300 illegal requests -> illegal_count saturates at 255.
- Continuous push and pop every cycle for 20 requests with out_ready=1 -> one word per cycle after 1 cycle latency, occupancy stays <=1, pointer wrap is correct.
- Fill 3 entries, assert rst_n=0 mid-cycle -> out_valid=0 and out_instr=0 immediately. After release the FIFO is empty and all counters are 0.
